broken_array_mult_seq: RTL

Iterative controller for the approximate broken-array multiplier. It reuses a single row of partial-product-and-add cells over several cycles, adding one multiplier row per cycle.
Broken-array approximation is applied at compile time:
- HBL omits the lowest multiplier rows.
- VBL clears the lowest product columns of every partial product.

Operands arrive and products leave over valid/ready handshakes, so the block can sit between operand buffers and the accumulator stage.

---
 rtl/broken_array_mult_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/broken_array_mult_seq.sv
// ---------------------------------------------------------------------------
// broken_array_mult_seq
//
// Iterative approximate broken-array multiplier. A single row of
// partial-product-and-add logic is reused over several cycles. Each RUN
// cycle adds one multiplier row into the accumulator.
//
// The approximation is fixed when the design is elaborated:
//   HBL - the HBL least-significant multiplier rows are never added.
//   VBL - product columns [VBL-1:0] are cleared in every partial product.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   in_valid_i     operand pair valid
//   in_ready_o     block can accept operands (high only in IDLE)
//   multiplicand_i operand A, WIDTH bits
//   multiplier_i   operand B, WIDTH bits
//   out_valid_o    product_o holds a finished result
//   out_ready_i    consumer accepts the product
//   product_o      approximate product, 2*WIDTH bits, registered
//   busy_o         high while rows are being accumulated
// ---------------------------------------------------------------------------
module broken_array_mult_seq #(
    parameter int WIDTH      = 8,
    parameter int HBL        = 0,
    parameter int VBL        = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Reject illegal approximation settings at elaboration.
    generate
        if (WIDTH < 1 || HBL < 0 || HBL > WIDTH - 1 || VBL < 0 || VBL > 2 * WIDTH) begin : g_bad_params
            $error("broken_array_mult_seq: HBL must be 0..WIDTH-1 and VBL 0..2*WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [PW-1:0]      acc_reg;
    logic [PW-1:0]      product_reg;
    logic               out_valid_reg;
    logic [CNT_W-1:0]   row_reg;

    logic [PW-1:0]      col_mask;
    logic [PW-1:0]      row_term;
    logic [PW-1:0]      acc_next;
    logic [WIDTH-1:0]   upper_zero;
    logic               last_row;

    // Column mask: vertical break line clears the VBL lowest columns.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_col_mask
            assign col_mask[gi] = (gi >= VBL);
        end
    endgenerate

    // upper_zero[r] is set when every multiplier bit above row r is zero,
    // i.e. no further row can contribute to the sum.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_upper_zero
            if (gi == WIDTH - 1) begin : g_top
                assign upper_zero[gi] = 1'b1;
            end else begin : g_rest
                assign upper_zero[gi] = ~|b_reg[WIDTH-1:gi+1];
            end
        end
    endgenerate

    // The single reused partial-product row plus its adder.
    always_comb begin
        row_term = '0;
        if (b_reg[row_reg]) begin
            row_term = ({{WIDTH{1'b0}}, a_reg} << row_reg) & col_mask;
        end
        acc_next = acc_reg + row_term;
        last_row = (row_reg == CNT_W'(WIDTH - 1)) ||
                   ((EARLY_EXIT != 0) && upper_zero[row_reg]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
            row_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid_i) begin
                        a_reg     <= multiplicand_i;
                        b_reg     <= multiplier_i;
                        acc_reg   <= '0;
                        row_reg   <= CNT_W'(HBL);
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    if (last_row) begin
                        product_reg   <= acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        row_reg <= row_reg + 1'b1;
                    end
                end
                DONE: begin
                    // product_reg is left untouched so the last result
                    // remains visible until the next completion.
                    if (out_ready_i) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags depend on the state register only.
    assign in_ready_o  = (state_reg == IDLE);
    assign busy_o      = (state_reg == RUN);
    assign out_valid_o = out_valid_reg;
    assign product_o   = product_reg;

endmodule
